// File: rtl/exa_crosb_pkg.sv
// exa_crosb_pkg: shared types and helpers for the VC crossbar output scheduler.
// Watchdog option: define EXA_CROSB_SCHED_WDOG_EN.
package exa_crosb_pkg;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_BUSY = 1'b1
    } sched_state_t;

    function automatic int unsigned sched_class(
        input int unsigned vc_idx,
        input int unsigned vc_num
    );
        return vc_idx / vc_num;
    endfunction

endpackage

// File: rtl/exa_crosb_rr_pick.sv
// exa_crosb_rr_pick: combinational round-robin picker, search starts at ptr
// and wraps to the lowest requester when nothing sits at or above ptr.
module exa_crosb_rr_pick
    import exa_crosb_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] lo_idx;
    logic [W-1:0] hi_idx;
    logic         hi_any;

    // Descending scan: the last hit written is the lowest index.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_any = 1'b0;
        any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = W'(i);
                any    = 1'b1;
                if (W'(i) >= ptr) begin
                    hi_idx = W'(i);
                    hi_any = 1'b1;
                end
            end
        end
        idx    = hi_any ? hi_idx : lo_idx;
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/exa_crosb_out_sched.sv
// exa_crosb_out_sched: per-output packet scheduler, strict priority across
// classes, round-robin within a class. Option: EXA_CROSB_SCHED_WDOG_EN.
module exa_crosb_out_sched
    import exa_crosb_pkg::*;
#(
    parameter int input_num   = 16,
    parameter int vc_num      = 3,
    parameter int prio_num    = 2,
    parameter int logVcPrio   = $clog2(prio_num * vc_num),
    parameter int logInput    = $clog2(input_num),
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [input_num-1:0]                i_req,
    input  logic [input_num-1:0][logVcPrio-1:0] i_req_vc,
    input  logic [prio_num*vc_num-1:0]          i_credits,
    input  logic                                i_beat_valid,
    input  logic                                i_beat_ready,
    input  logic                                i_beat_last,
    output logic [input_num-1:0]                o_grant,
    output logic                                o_grant_valid,
    output logic [logInput-1:0]                 o_sel_input,
    output logic [logVcPrio-1:0]                o_sel_vc,
    output logic                                o_wdog_timeout
);

    localparam int NVC    = prio_num * vc_num;
    localparam int NVC_P2 = 1 << logVcPrio;

    sched_state_t         state_q, state_d;
    logic [input_num-1:0] grant_q, grant_d;
    logic                 gv_q, gv_d;
    logic [logInput-1:0]  sel_in_q, sel_in_d;
    logic [logVcPrio-1:0] sel_vc_q, sel_vc_d;
    logic [logInput-1:0]  rr_q, rr_d;

    logic [NVC_P2-1:0]    cred_ext;
    logic [input_num-1:0] elig;
    logic [input_num-1:0] cand;
    logic [prio_num-1:0]  cls_hit;
    int unsigned          win_cls;
    logic [input_num-1:0] pick_oh;
    logic [logInput-1:0]  pick_idx;
    logic                 pick_any;
    logic                 tail_acc;
    logic                 wdog_hit;

    // Padding lets out-of-range VC indices read a safe zero credit.
    assign cred_ext = NVC_P2'(i_credits);
    assign tail_acc = i_beat_valid && i_beat_ready && i_beat_last;

    always_comb begin
        elig    = '0;
        cand    = '0;
        cls_hit = '0;
        win_cls = 0;
        for (int i = 0; i < input_num; i++) begin
            elig[i] = i_req[i] && (32'(i_req_vc[i]) < NVC)
                      && cred_ext[i_req_vc[i]];
        end
        for (int p = 0; p < prio_num; p++) begin
            for (int i = 0; i < input_num; i++) begin
                if (elig[i] && sched_class(32'(i_req_vc[i]), vc_num) == p)
                    cls_hit[p] = 1'b1;
            end
        end
        for (int p = 0; p < prio_num; p++) begin
            if (cls_hit[p]) win_cls = p;
        end
        for (int i = 0; i < input_num; i++) begin
            cand[i] = elig[i]
                      && sched_class(32'(i_req_vc[i]), vc_num) == win_cls;
        end
    end

    exa_crosb_rr_pick #(
        .N(input_num),
        .W(logInput)
    ) u_pick (
        .req   (cand),
        .ptr   (rr_q),
        .onehot(pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gv_d     = gv_q;
        sel_in_d = sel_in_q;
        sel_vc_d = sel_vc_q;
        rr_d     = rr_q;
        unique case (state_q)
            SCHED_IDLE: begin
                if (pick_any) begin
                    state_d  = SCHED_BUSY;
                    grant_d  = pick_oh;
                    gv_d     = 1'b1;
                    sel_in_d = pick_idx;
                    sel_vc_d = i_req_vc[pick_idx];
                    rr_d     = (32'(pick_idx) == input_num - 1)
                               ? '0 : pick_idx + 1'b1;
                end
            end
            SCHED_BUSY: begin
                if (tail_acc || wdog_hit) begin
                    state_d  = SCHED_IDLE;
                    grant_d  = '0;
                    gv_d     = 1'b0;
                    sel_in_d = '0;
                    sel_vc_d = '0;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= SCHED_IDLE;
            grant_q  <= '0;
            gv_q     <= 1'b0;
            sel_in_q <= '0;
            sel_vc_q <= '0;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gv_q     <= gv_d;
            sel_in_q <= sel_in_d;
            sel_vc_q <= sel_vc_d;
            rr_q     <= rr_d;
        end
    end

`ifdef EXA_CROSB_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    logic [WW-1:0] wdog_q;
    logic          beat_acc;

    assign beat_acc = i_beat_valid && i_beat_ready;
    assign wdog_hit = (state_q == SCHED_BUSY)
                      && (wdog_q == WW'(WDOG_CYCLES));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            wdog_q <= '0;
        else if (state_q != SCHED_BUSY || beat_acc || wdog_hit)
            wdog_q <= '0;
        else
            wdog_q <= wdog_q + 1'b1;
    end
`else
    assign wdog_hit = (WDOG_CYCLES < 0);
`endif

    assign o_grant        = grant_q;
    assign o_grant_valid  = gv_q;
    assign o_sel_input    = sel_in_q;
    assign o_sel_vc       = sel_vc_q;
    assign o_wdog_timeout = wdog_hit;

endmodule

// File: tb/tb_exa_crosb_out_sched.sv
// tb_exa_crosb_out_sched: directed stimulus with a grant scoreboard and an
// independent monitor; watchdog case runs when EXA_CROSB_SCHED_WDOG_EN is set.
module tb_exa_crosb_out_sched;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic [15:0]       i_req;
    logic [15:0][2:0]  i_req_vc;
    logic [5:0]        i_credits;
    logic              i_beat_valid;
    logic              i_beat_ready;
    logic              i_beat_last;
    logic [15:0]       o_grant;
    logic              o_grant_valid;
    logic [3:0]        o_sel_input;
    logic [2:0]        o_sel_vc;
    logic              o_wdog_timeout;

    typedef struct {
        int inp;
        int vc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic pv = 1'b0;

    exa_crosb_out_sched #(.WDOG_CYCLES(16)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .i_req         (i_req),
        .i_req_vc      (i_req_vc),
        .i_credits     (i_credits),
        .i_beat_valid  (i_beat_valid),
        .i_beat_ready  (i_beat_ready),
        .i_beat_last   (i_beat_last),
        .o_grant       (o_grant),
        .o_grant_valid (o_grant_valid),
        .o_sel_input   (o_sel_input),
        .o_sel_vc      (o_sel_vc),
        .o_wdog_timeout(o_wdog_timeout)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every new grant must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (o_grant_valid && !pv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got input %0d vc %0d expected none",
                             o_sel_input, o_sel_vc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sel_input", 32'(o_sel_input), e.inp);
                    chk("sb_sel_vc", 32'(o_sel_vc), e.vc);
                    chk("sb_grant_oh", 32'(o_grant), 32'(1) << e.inp);
                end
            end
            pv = o_grant_valid;
        end
    end

    task automatic send(input int n);
        for (int b = 0; b < n; b++) begin
            i_beat_valid = 1'b1;
            i_beat_ready = 1'b1;
            i_beat_last  = (b == n - 1);
            @(negedge ACLK);
        end
        i_beat_valid = 1'b0;
        i_beat_last  = 1'b0;
    endtask

    initial begin
        ARESETN      = 1'b0;
        i_req        = '0;
        i_req_vc     = '0;
        i_credits    = '1;
        i_beat_valid = 1'b0;
        i_beat_ready = 1'b0;
        i_beat_last  = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_gv", 32'(o_grant_valid), 0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_sel_in", 32'(o_sel_input), 0);
        chk("rst_sel_vc", 32'(o_sel_vc), 0);
        chk("rst_wdog", 32'(o_wdog_timeout), 0);
        ARESETN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            chk("idle_gv", 32'(o_grant_valid), 0);
            chk("idle_grant", 32'(o_grant), 0);
        end

        // Round-robin between inputs 2 and 5, class 0
        exp_q.push_back('{2, 1});
        exp_q.push_back('{5, 1});
        i_req[2] = 1'b1; i_req_vc[2] = 3'd1;
        i_req[5] = 1'b1; i_req_vc[5] = 3'd1;
        @(negedge ACLK);
        chk("rr_lat_gv", 32'(o_grant_valid), 1);
        chk("rr_lat_sel", 32'(o_sel_input), 2);
        i_req[2] = 1'b0;
        send(3);
        chk("rr_bubble", 32'(o_grant_valid), 0);
        @(negedge ACLK);
        chk("rr_second", 32'(o_sel_input), 5);
        i_req[5] = 1'b0;
        send(3);
        chk("rr_ptr6", 32'(dut.rr_q), 6);
        chk("rr_done_gv", 32'(o_grant_valid), 0);

        // Class 1 beats class 0; single-beat packets
        exp_q.push_back('{7, 4});
        exp_q.push_back('{3, 0});
        i_req[3] = 1'b1; i_req_vc[3] = 3'd0;
        i_req[7] = 1'b1; i_req_vc[7] = 3'd4;
        @(negedge ACLK);
        chk("prio_vc", 32'(o_sel_vc), 4);
        i_req[7] = 1'b0;
        send(1);
        chk("prio_bubble", 32'(o_grant_valid), 0);
        @(negedge ACLK);
        chk("prio_low", 32'(o_sel_input), 3);
        i_req[3] = 1'b0;
        send(1);
        chk("prio_ptr", 32'(dut.rr_q), 4);

        // No credit, no grant
        i_credits[2] = 1'b0;
        i_req[4] = 1'b1; i_req_vc[4] = 3'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            chk("cred_block", 32'(o_grant_valid), 0);
        end
        exp_q.push_back('{4, 2});
        i_credits[2] = 1'b1;
        @(negedge ACLK);
        chk("cred_gv", 32'(o_grant_valid), 1);
        chk("cred_sel", 32'(o_sel_input), 4);
        i_req[4] = 1'b0;
        send(2);

        // Out-of-range VC index is never eligible
        i_req[6] = 1'b1; i_req_vc[6] = 3'd6;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            chk("oor_block", 32'(o_grant_valid), 0);
        end
        i_req[6] = 1'b0;

        // Frozen grant, backpressured tail
        exp_q.push_back('{1, 5});
        i_req[1] = 1'b1; i_req_vc[1] = 3'd5;
        @(negedge ACLK);
        chk("hold_sel", 32'(o_sel_input), 1);
        i_req[1]  = 1'b0;
        i_credits = '0;
        i_beat_valid = 1'b1; i_beat_ready = 1'b1; i_beat_last = 1'b0;
        @(negedge ACLK);
        chk("hold_mid", 32'(o_grant_valid), 1);
        i_beat_ready = 1'b0; i_beat_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            chk("hold_bp_gv", 32'(o_grant_valid), 1);
            chk("hold_bp_vc", 32'(o_sel_vc), 5);
        end
        i_beat_ready = 1'b1;
        @(negedge ACLK);
        chk("hold_tail", 32'(o_grant_valid), 0);
        i_beat_valid = 1'b0; i_beat_last = 1'b0;
        i_credits = '1;

        // Asynchronous reset mid-packet
        exp_q.push_back('{1, 5});
        i_req[1] = 1'b1;
        @(negedge ACLK);
        chk("arst_pre", 32'(o_grant_valid), 1);
        i_req[1] = 1'b0;
        i_beat_valid = 1'b1; i_beat_ready = 1'b1;
        @(negedge ACLK);
        i_beat_valid = 1'b0;
        #2 ARESETN = 1'b0;
        #1;
        chk("arst_gv", 32'(o_grant_valid), 0);
        chk("arst_grant", 32'(o_grant), 0);
        chk("arst_sel_in", 32'(o_sel_input), 0);
        chk("arst_sel_vc", 32'(o_sel_vc), 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        chk("arst_ptr", 32'(dut.rr_q), 0);

`ifdef EXA_CROSB_SCHED_WDOG_EN
        exp_q.push_back('{0, 0});
        i_req[0] = 1'b1; i_req_vc[0] = 3'd0;
        @(negedge ACLK);
        chk("wd_gv", 32'(o_grant_valid), 1);
        i_req[0] = 1'b0;
        for (int c = 1; c < 16; c++) begin
            @(negedge ACLK);
            chk("wd_quiet", 32'(o_wdog_timeout), 0);
        end
        @(negedge ACLK);
        chk("wd_pulse", 32'(o_wdog_timeout), 1);
        chk("wd_pulse_gv", 32'(o_grant_valid), 1);
        @(negedge ACLK);
        chk("wd_after", 32'(o_wdog_timeout), 0);
        chk("wd_release", 32'(o_grant_valid), 0);
`endif

        repeat (2) @(negedge ACLK);
        chk("sb_drain", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
